lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 36 +++
 rtl/lsu.sv | 177 +++++++++++++++++
 tb/tb_lsu.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// LSU signal bundle: EXU-side op handshake, word-wide memory bus and writeback results.
interface lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] data_ram;
  logic        done;
  logic        err;
  logic        busy;

  modport slave (
    input  in_valid, is_load, is_store, funct3, addr, wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output data_ram, done, err, busy
  );

  modport master (
    output in_valid, is_load, is_store, funct3, addr, wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  data_ram, done, err, busy
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one EXU memory op -> one bus access -> extended writeback data.
// Optional define LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses without using the bus.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] data_ram_q, data_ram_d;
  logic        ready_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [29:0] waddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic        accept;
  logic [7:0]  cnt_inc;
  logic        cnt_hit;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_data;

  assign accept  = bus.in_valid & (bus.is_load | bus.is_store) & ready_q & (state_q == IDLE);
  assign cnt_inc = cnt_q + 8'd1;
  assign cnt_hit = (cnt_inc == TIMEOUT_LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = ((bus.funct3[1:0] == 2'b01) & bus.addr[0]) |
                    (bus.funct3[1] & (bus.addr[1:0] != 2'b00));
`endif

  // Narrow stores replicate their data across the word; the byte enables pick the live lane.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << bus.addr[1:0];
        wdata_new = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {bus.addr[1], 1'b0};
        wdata_new = {2{bus.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (lane_q)
      2'd0:    rbyte = bus.mem_rdata[7:0];
      2'd1:    rbyte = bus.mem_rdata[15:8];
      2'd2:    rbyte = bus.mem_rdata[23:16];
      default: rbyte = bus.mem_rdata[31:24];
    endcase
    rhalf = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{rbyte[7]}}, rbyte};
      3'b100:  load_data = {24'h0, rbyte};
      3'b001:  load_data = {{16{rhalf[15]}}, rhalf};
      3'b101:  load_data = {16'h0, rhalf};
      default: load_data = bus.mem_rdata;
    endcase
  end

  // A response beats a timeout that expires in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    data_ram_d = data_ram_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = 8'd0;
          err_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misalign) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
`else
          state_d = REQ;
`endif
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (bus.mem_gnt && bus.mem_rvalid) begin
          state_d = RESP;
          if (!we_q) data_ram_d = load_data;
        end else if (cnt_hit) begin
          state_d    = RESP;
          err_d      = 1'b1;
          data_ram_d = 32'h0;
        end else if (bus.mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (bus.mem_rvalid) begin
          state_d = RESP;
          if (!we_q) data_ram_d = load_data;
        end else if (cnt_hit) begin
          state_d    = RESP;
          err_d      = 1'b1;
          data_ram_d = 32'h0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready_q keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      data_ram_q <= 32'h0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      lane_q     <= 2'b00;
      waddr_q    <= 30'h0;
      wdata_q    <= 32'h0;
      be_q       <= 4'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      data_ram_q <= data_ram_d;
      ready_q    <= 1'b1;
      if (accept) begin
        we_q    <= bus.is_store;
        f3_q    <= bus.funct3;
        lane_q  <= bus.addr[1:0];
        waddr_q <= bus.addr[31:2];
        wdata_q <= wdata_new;
        be_q    <= be_new;
      end
    end
  end

  assign bus.in_ready  = ready_q & (state_q == IDLE);
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = (state_q == REQ) & we_q;
  assign bus.mem_addr  = {waddr_q, 2'b00};
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.data_ram  = data_ram_q;
  assign bus.done      = (state_q == RESP);
  assign bus.err       = (state_q == RESP) & err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: scoreboard of expected writeback results plus per-scenario tasks.
module tb_lsu;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic [31:0] model_ram = 32'h0;
  exp_t sb[$];

  lsu_if b0();
  lsu_if b1();

  lsu #(.TIMEOUT_CYCLES(255)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  lsu #(.TIMEOUT_CYCLES(4))   dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b0.in_valid = 0; b0.is_load = 0; b0.is_store = 0; b0.funct3 = 3'b000;
    b0.addr = 32'h0; b0.wdata = 32'h0; b0.mem_gnt = 0; b0.mem_rvalid = 0; b0.mem_rdata = 32'h0;
    b1.in_valid = 0; b1.is_load = 0; b1.is_store = 0; b1.funct3 = 3'b000;
    b1.addr = 32'h0; b1.wdata = 32'h0; b1.mem_gnt = 0; b1.mem_rvalid = 0; b1.mem_rdata = 32'h0;
  endtask

  // Presents one op to dut0 for a single cycle; returns just after the accept edge.
  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
    b0.in_valid = 1; b0.is_load = ld; b0.is_store = st; b0.funct3 = f3; b0.addr = a; b0.wdata = wd;
    start_cyc = cyc;
    tick();
    b0.in_valid = 0; b0.is_load = 0; b0.is_store = 0;
  endtask

  task automatic respond_b0(input logic [31:0] rd);
    b0.mem_gnt = 1; b0.mem_rvalid = 1; b0.mem_rdata = rd;
    tick();
    b0.mem_gnt = 0; b0.mem_rvalid = 0;
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    e = exp_t'{data: 32'h0, err: 1'b0};
    if (ok) e = sb.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    tick();
    tick();
    checks++;
    if ({b0.in_ready, b0.mem_req, b0.mem_we, b0.done, b0.err, b0.busy} !== 6'b0 ||
        b0.mem_addr !== 32'h0 || b0.mem_wdata !== 32'h0 || b0.mem_be !== 4'h0 || b0.data_ram !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ctrl=%b addr=%h wdata=%h be=%b data_ram=%h, required all zero",
               {b0.in_ready, b0.mem_req, b0.mem_we, b0.done, b0.err, b0.busy},
               b0.mem_addr, b0.mem_wdata, b0.mem_be, b0.data_ram);
    end
    rst_n = 1;
    checks++;
    if (b0.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: in_ready=%b, required 0 before first edge", b0.in_ready);
    end
    tick();
    checks++;
    if (b0.in_ready !== 1'b1 || b1.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_release: in_ready=%b/%b, required 1/1", b0.in_ready, b1.in_ready);
    end
  endtask

  task automatic test_lb();
    exp_t e; bit ok;
    model_ram = 32'hFFFF_FF80;
    sb.push_back(exp_t'{data: model_ram, err: 1'b0});
    drive_op(1, 0, 3'b000, 32'h0000_0103, 32'h0);
    checks++;
    if (b0.mem_req !== 1'b1 || b0.mem_addr !== 32'h100 || b0.mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lb_req: req=%b addr=%h we=%b, required 1 00000100 0", b0.mem_req, b0.mem_addr, b0.mem_we);
    end
    respond_b0(32'h80FF_FF12);
    checks++;
    if (b0.done !== 1'b1 || (cyc - start_cyc) != 2) begin
      errors++;
      $display("[TB] FAIL lb_latency: done=%b latency=%0d, required done=1 latency=2", b0.done, cyc - start_cyc);
    end
    pop_exp(e, ok);
    checks++;
    if (!ok || b0.data_ram !== e.data || b0.err !== e.err) begin
      errors++;
      $display("[TB] FAIL lb_result: data_ram=%h err=%b, required %h %b", b0.data_ram, b0.err, e.data, e.err);
    end
    tick();
    checks++;
    if (b0.done !== 1'b0 || b0.in_ready !== 1'b1 || b0.data_ram !== model_ram) begin
      errors++;
      $display("[TB] FAIL lb_after: done=%b in_ready=%b data_ram=%h, required 0 1 %h",
               b0.done, b0.in_ready, b0.data_ram, model_ram);
    end
  endtask

  task automatic test_sh_stall();
    exp_t e; bit ok;
    sb.push_back(exp_t'{data: model_ram, err: 1'b0});
    drive_op(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b0.mem_req !== 1'b1 || b0.mem_we !== 1'b1 || b0.mem_addr !== 32'h200 ||
          b0.mem_be !== 4'b1100 || b0.mem_wdata !== 32'hABCD_ABCD) begin
        errors++;
        $display("[TB] FAIL sh_req_stable[%0d]: req=%b we=%b addr=%h be=%b wdata=%h, required 1 1 00000200 1100 abcdabcd",
                 i, b0.mem_req, b0.mem_we, b0.mem_addr, b0.mem_be, b0.mem_wdata);
      end
      if (i == 3) b0.mem_gnt = 1;
      tick();
    end
    b0.mem_gnt = 0;
    checks++;
    if (b0.mem_req !== 1'b0 || b0.busy !== 1'b1 || b0.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sh_wait: req=%b busy=%b done=%b, required 0 1 0", b0.mem_req, b0.busy, b0.done);
    end
    b0.mem_rvalid = 1; b0.mem_rdata = 32'h5555_AAAA;
    tick();
    b0.mem_rvalid = 0;
    pop_exp(e, ok);
    checks++;
    if (!ok || b0.done !== 1'b1 || b0.data_ram !== e.data || b0.err !== e.err) begin
      errors++;
      $display("[TB] FAIL sh_done: done=%b data_ram=%h err=%b, required 1 %h %b", b0.done, b0.data_ram, b0.err, e.data, e.err);
    end
    tick();
  endtask

  task automatic test_lhu_wait();
    exp_t e; bit ok;
    model_ram = 32'h0000_5678;
    sb.push_back(exp_t'{data: model_ram, err: 1'b0});
    drive_op(1, 0, 3'b101, 32'h0000_0010, 32'h0);
    b0.mem_gnt = 1;
    tick();
    b0.mem_gnt = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (b0.busy !== 1'b1 || b0.done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL lhu_busy[%0d]: busy=%b done=%b, required 1 0", i, b0.busy, b0.done);
      end
      if (i == 3) begin b0.mem_rvalid = 1; b0.mem_rdata = 32'h1234_5678; end
      tick();
    end
    b0.mem_rvalid = 0;
    pop_exp(e, ok);
    checks++;
    if (!ok || b0.done !== 1'b1 || b0.busy !== 1'b1 || b0.data_ram !== e.data || b0.err !== e.err) begin
      errors++;
      $display("[TB] FAIL lhu_done: done=%b busy=%b data_ram=%h err=%b, required 1 1 %h %b",
               b0.done, b0.busy, b0.data_ram, b0.err, e.data, e.err);
    end
    tick();
  endtask

  task automatic test_load_extend();
    exp_t e; bit ok;
    logic [2:0]  f3s  [6] = '{3'b100, 3'b000, 3'b001, 3'b010, 3'b101, 3'b000};
    logic [31:0] adrs [6] = '{32'h102, 32'h100, 32'h102, 32'h104, 32'h002, 32'h101};
    logic [31:0] rds  [6] = '{32'h80FF_FF12, 32'h80FF_FF12, 32'h80FF_FF12, 32'hDEAD_BEEF, 32'h8001_7FFF, 32'h0000_7F00};
    logic [31:0] exs  [6] = '{32'h0000_00FF, 32'h0000_0012, 32'hFFFF_80FF, 32'hDEAD_BEEF, 32'h0000_8001, 32'h0000_007F};
    for (int i = 0; i < 6; i++) begin
      model_ram = exs[i];
      sb.push_back(exp_t'{data: model_ram, err: 1'b0});
      drive_op(1, 0, f3s[i], adrs[i], 32'h0);
      checks++;
      if (b0.mem_addr !== (adrs[i] & 32'hFFFF_FFFC)) begin
        errors++;
        $display("[TB] FAIL load_addr[%0d]: mem_addr=%h, required %h", i, b0.mem_addr, adrs[i] & 32'hFFFF_FFFC);
      end
      respond_b0(rds[i]);
      pop_exp(e, ok);
      checks++;
      if (!ok || b0.done !== 1'b1 || b0.data_ram !== e.data || b0.err !== e.err) begin
        errors++;
        $display("[TB] FAIL load_extend[%0d]: done=%b data_ram=%h err=%b, required 1 %h %b",
                 i, b0.done, b0.data_ram, b0.err, e.data, e.err);
      end
      tick();
    end
  endtask

  task automatic test_store_lanes();
    exp_t e; bit ok;
    logic        lds [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s [5] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b010};
    logic [31:0] adrs[5] = '{32'h001, 32'h003, 32'h000, 32'h008, 32'h00C};
    logic [31:0] wds [5] = '{32'h1234_56A5, 32'h0000_003C, 32'hFFFF_1234, 32'hCAFE_F00D, 32'h0102_0304};
    logic [3:0]  bes [5] = '{4'b0010, 4'b1000, 4'b0011, 4'b1111, 4'b1111};
    logic [31:0] ews [5] = '{32'hA5A5_A5A5, 32'h3C3C_3C3C, 32'h1234_1234, 32'hCAFE_F00D, 32'h0102_0304};
    for (int i = 0; i < 5; i++) begin
      sb.push_back(exp_t'{data: model_ram, err: 1'b0});
      drive_op(lds[i], 1'b1, f3s[i], adrs[i], wds[i]);
      checks++;
      if (b0.mem_we !== 1'b1 || b0.mem_be !== bes[i] || b0.mem_wdata !== ews[i]) begin
        errors++;
        $display("[TB] FAIL store_lanes[%0d]: we=%b be=%b wdata=%h, required 1 %b %h",
                 i, b0.mem_we, b0.mem_be, b0.mem_wdata, bes[i], ews[i]);
      end
      respond_b0(32'hFFFF_FFFF);
      pop_exp(e, ok);
      checks++;
      if (!ok || b0.done !== 1'b1 || b0.data_ram !== e.data || b0.err !== e.err) begin
        errors++;
        $display("[TB] FAIL store_done[%0d]: done=%b data_ram=%h err=%b, required 1 %h %b",
                 i, b0.done, b0.data_ram, b0.err, e.data, e.err);
      end
      tick();
    end
  endtask

  task automatic test_ignored_inputs();
    b0.in_valid = 1; b0.is_load = 0; b0.is_store = 0; b0.funct3 = 3'b010; b0.addr = 32'h40;
    tick();
    b0.in_valid = 0;
    checks++;
    if (b0.busy !== 1'b0 || b0.in_ready !== 1'b1 || b0.mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_no_op: busy=%b in_ready=%b req=%b, required 0 1 0", b0.busy, b0.in_ready, b0.mem_req);
    end
    b0.mem_gnt = 1; b0.mem_rvalid = 1; b0.mem_rdata = 32'h7777_7777;
    tick();
    b0.mem_gnt = 0; b0.mem_rvalid = 0;
    checks++;
    if (b0.busy !== 1'b0 || b0.done !== 1'b0 || b0.data_ram !== model_ram) begin
      errors++;
      $display("[TB] FAIL stray_idle: busy=%b done=%b data_ram=%h, required 0 0 %h", b0.busy, b0.done, b0.data_ram, model_ram);
    end
  endtask

  task automatic test_misalign();
    exp_t e; bit ok;
`ifdef LSU_MISALIGN_TRAP_EN
    sb.push_back(exp_t'{data: model_ram, err: 1'b1});
    drive_op(1, 0, 3'b010, 32'h0000_0006, 32'h0);
    checks++;
    if (b0.mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL misalign_no_bus: req=%b, required 0", b0.mem_req);
    end
`else
    model_ram = 32'h600D_CAFE;
    sb.push_back(exp_t'{data: model_ram, err: 1'b0});
    drive_op(1, 0, 3'b010, 32'h0000_0006, 32'h0);
    checks++;
    if (b0.mem_req !== 1'b1 || b0.mem_addr !== 32'h4) begin
      errors++;
      $display("[TB] FAIL misalign_addr: req=%b addr=%h, required 1 00000004", b0.mem_req, b0.mem_addr);
    end
    respond_b0(32'h600D_CAFE);
`endif
    pop_exp(e, ok);
    checks++;
    if (!ok || b0.done !== 1'b1 || b0.data_ram !== e.data || b0.err !== e.err) begin
      errors++;
      $display("[TB] FAIL misalign_done: done=%b data_ram=%h err=%b, required 1 %h %b",
               b0.done, b0.data_ram, b0.err, e.data, e.err);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e; bit ok;
    logic [31:0] rds[3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    for (int i = 0; i < 3; i++) begin
      model_ram = rds[i];
      sb.push_back(exp_t'{data: model_ram, err: 1'b0});
      drive_op(1, 0, 3'b010, 32'h80 + 32'(i * 4), 32'h0);
      respond_b0(rds[i]);
      pop_exp(e, ok);
      checks++;
      if (!ok || b0.done !== 1'b1 || b0.data_ram !== e.data || b0.err !== e.err || (cyc - start_cyc) != 2) begin
        errors++;
        $display("[TB] FAIL b2b_done[%0d]: done=%b data_ram=%h err=%b latency=%0d, required 1 %h %b 2",
                 i, b0.done, b0.data_ram, b0.err, cyc - start_cyc, e.data, e.err);
      end
      // Next op is already offered and a stray response arrives during RESP; both must be ignored.
      b0.in_valid = 1; b0.is_load = 1; b0.funct3 = 3'b010; b0.addr = 32'h90;
      b0.mem_gnt = 1; b0.mem_rvalid = 1; b0.mem_rdata = 32'hBAD0_BAD0;
      tick();
      b0.in_valid = 0; b0.is_load = 0; b0.mem_gnt = 0; b0.mem_rvalid = 0;
      checks++;
      if (b0.busy !== 1'b0 || b0.in_ready !== 1'b1 || b0.data_ram !== model_ram) begin
        errors++;
        $display("[TB] FAIL b2b_resp_ignore[%0d]: busy=%b in_ready=%b data_ram=%h, required 0 1 %h",
                 i, b0.busy, b0.in_ready, b0.data_ram, model_ram);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    bit req_drop;
    b1.in_valid = 1; b1.is_load = 1; b1.funct3 = 3'b010; b1.addr = 32'h40;
    tick();
    b1.in_valid = 0;
    b1.mem_gnt = 1; b1.mem_rvalid = 1; b1.mem_rdata = 32'hCAFE_BABE;
    tick();
    b1.mem_gnt = 0; b1.mem_rvalid = 0;
    checks++;
    if (b1.done !== 1'b1 || b1.err !== 1'b0 || b1.data_ram !== 32'hCAFE_BABE) begin
      errors++;
      $display("[TB] FAIL to_preload: done=%b err=%b data_ram=%h, required 1 0 cafebabe", b1.done, b1.err, b1.data_ram);
    end
    tick();
    b1.in_valid = 1; b1.is_load = 1; b1.funct3 = 3'b010; b1.addr = 32'h44;
    tick();
    b1.in_valid = 0;
    n = 1;
    req_drop = 0;
    while (b1.done !== 1'b1 && n < 20) begin
      if (b1.mem_req !== 1'b1) req_drop = 1;
      tick();
      n++;
    end
    checks++;
    if (b1.done !== 1'b1 || n != 5) begin
      errors++;
      $display("[TB] FAIL to_latency: done=%b edges=%0d, required 1 5", b1.done, n);
    end
    checks++;
    if (b1.err !== 1'b1 || b1.data_ram !== 32'h0 || b1.mem_req !== 1'b0 || req_drop) begin
      errors++;
      $display("[TB] FAIL to_result: err=%b data_ram=%h req=%b req_dropped_early=%b, required 1 00000000 0 0",
               b1.err, b1.data_ram, b1.mem_req, req_drop);
    end
    tick();
    checks++;
    if (b1.mem_req !== 1'b0 || b1.done !== 1'b0 || b1.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL to_after: req=%b done=%b in_ready=%b, required 0 0 1", b1.mem_req, b1.done, b1.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; bit ok;
    bit clean;
    drive_op(1, 0, 3'b010, 32'h0000_0020, 32'h0);
    b0.mem_gnt = 1;
    tick();
    b0.mem_gnt = 0;
    checks++;
    if (b0.busy !== 1'b1 || b0.mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_wait: busy=%b req=%b, required 1 0", b0.busy, b0.mem_req);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({b0.in_ready, b0.mem_req, b0.mem_we, b0.done, b0.err, b0.busy} !== 6'b0 ||
        b0.mem_addr !== 32'h0 || b0.mem_wdata !== 32'h0 || b0.mem_be !== 4'h0 || b0.data_ram !== 32'h0) begin
      errors++;
      $display("[TB] FAIL rst_mid_outputs: ctrl=%b addr=%h wdata=%h be=%b data_ram=%h, required all zero",
               {b0.in_ready, b0.mem_req, b0.mem_we, b0.done, b0.err, b0.busy},
               b0.mem_addr, b0.mem_wdata, b0.mem_be, b0.data_ram);
    end
    tick();
    rst_n = 1;
    model_ram = 32'h0;
    b0.mem_rvalid = 1; b0.mem_rdata = 32'hFFFF_FFFF;
    clean = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      b0.mem_rvalid = 0;
      if (b0.done !== 1'b0 || b0.busy !== 1'b0 || b0.data_ram !== 32'h0) clean = 0;
    end
    checks++;
    if (!clean) begin
      errors++;
      $display("[TB] FAIL rst_mid_stray: done=%b busy=%b data_ram=%h, required 0 0 00000000 on every cycle",
               b0.done, b0.busy, b0.data_ram);
    end
    model_ram = 32'h0BAD_F00D;
    sb.push_back(exp_t'{data: model_ram, err: 1'b0});
    drive_op(1, 0, 3'b010, 32'h0000_0024, 32'h0);
    respond_b0(32'h0BAD_F00D);
    pop_exp(e, ok);
    checks++;
    if (!ok || b0.done !== 1'b1 || b0.data_ram !== e.data || b0.err !== e.err) begin
      errors++;
      $display("[TB] FAIL rst_mid_next: done=%b data_ram=%h err=%b, required 1 %h %b",
               b0.done, b0.data_ram, b0.err, e.data, e.err);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sh_stall();
    test_lhu_wait();
    test_load_extend();
    test_store_lanes();
    test_ignored_inputs();
    test_misalign();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
